// File: rtl/chorus_voice_engine.sv
// Multi-voice chorus: circular delay buffer, NUM_VOICES LFO-offset taps averaged into a wet
// signal and mixed with the dry sample. Define CHORUS_FEEDBACK_EN to feed the wet average back into the buffer.
module chorus_voice_engine #(
  parameter int PKT_WIDTH  = 16,
  parameter int BUF_DEPTH  = 4410,
  parameter int NUM_VOICES = 2,
  parameter int AVG_DELAY  = 882,
  parameter int OFF_W      = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PKT_WIDTH-1:0]           pkt_i,
  input  logic                           pktValid_i,
  input  logic [NUM_VOICES*OFF_W-1:0]    voiceOffset_i,
  input  logic [3:0]                     wetLevel_i,
  output logic [PKT_WIDTH-1:0]           pkt_o,
  output logic                           pktValid_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int DW     = AW + 1;
  localparam int FW     = $clog2(BUF_DEPTH + 1);
  localparam int VW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SHIFT  = $clog2(NUM_VOICES);
  localparam int ACC_W  = PKT_WIDTH + 2;
  localparam int MW     = PKT_WIDTH + 6;
  localparam logic [VW-1:0] V_LAST = VW'(NUM_VOICES - 1);
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-PKT_WIDTH+1){1'b0}}, {(PKT_WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-PKT_WIDTH+1){1'b1}}, {(PKT_WIDTH-1){1'b0}}};

  if (!(NUM_VOICES == 1 || NUM_VOICES == 2 || NUM_VOICES == 4)) begin : g_bad_voices
    $error("chorus_voice_engine: NUM_VOICES must be 1, 2 or 4");
  end
  if (BUF_DEPTH < 2 || AVG_DELAY < 1) begin : g_bad_depth
    $error("chorus_voice_engine: BUF_DEPTH must be >= 2 and AVG_DELAY >= 1");
  end
  if (AVG_DELAY + 2**OFF_W - 1 >= BUF_DEPTH) begin : g_bad_offset
    $error("chorus_voice_engine: AVG_DELAY + 2**OFF_W - 1 must be below BUF_DEPTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_MIX, S_WR} state_t;

  state_t                        state_q, state_d;
  logic [VW-1:0]                 v_q, v_d;
  logic [PKT_WIDTH-1:0]          dry_q, dry_d;
  logic [NUM_VOICES*OFF_W-1:0]   off_q, off_d;
  logic [3:0]                    wl_q, wl_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [PKT_WIDTH-1:0]          mix_q, mix_d;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]                 fill_q, fill_d;
  logic [PKT_WIDTH-1:0]          pkt_q, pkt_d;
  logic                          vld_q, vld_d;
  logic                          ovr_q, ovr_d;
  logic                          tap_ok_q, tap_ok_d;
  logic [PKT_WIDTH-1:0]          rd_data_q;
  logic [AW-1:0]                 rd_addr_d;
  logic                          wr_en;
  logic                          acc_en;

  logic [PKT_WIDTH-1:0]          mem [BUF_DEPTH];
  logic [OFF_W-1:0]              off_arr [NUM_VOICES];
  logic [OFF_W-1:0]              off_cur;
  logic [DW-1:0]                 tap_dly;
  logic [DW-1:0]                 wr_ext;
  logic signed [ACC_W-1:0]       tap_val;
  logic signed [ACC_W-1:0]       wet_avg;
  logic signed [MW-1:0]          dry_ext, wet_ext, k_dry, k_wet, mix_sum, mix_sh;
  logic [PKT_WIDTH-1:0]          wr_word;

  function automatic logic [PKT_WIDTH-1:0] sat_pkt(input logic signed [MW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[PKT_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[PKT_WIDTH-1:0];
    else                  return x[PKT_WIDTH-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_off
    assign off_arr[gi] = off_q[gi*OFF_W +: OFF_W];
  end

  // Tap address with explicit wrap so non-power-of-2 depths work.
  always_comb begin
    off_cur  = off_arr[v_q];
    tap_dly  = DW'(AVG_DELAY) + DW'(off_cur);
    wr_ext   = {1'b0, wr_ptr_q};
    if (wr_ext >= tap_dly) rd_addr_d = AW'(wr_ext - tap_dly);
    else                   rd_addr_d = AW'(wr_ext + DW'(BUF_DEPTH) - tap_dly);
    tap_ok_d = (32'(tap_dly) <= 32'(fill_q));
  end

  assign acc_en  = ((state_q == S_RD) && (v_q != '0)) || (state_q == S_ACC);
  assign tap_val = tap_ok_q ? {{(ACC_W-PKT_WIDTH){rd_data_q[PKT_WIDTH-1]}}, rd_data_q} : '0;
  assign wet_avg = acc_q >>> SHIFT;

  always_comb begin
    dry_ext = {{(MW-PKT_WIDTH){dry_q[PKT_WIDTH-1]}}, dry_q};
    wet_ext = {{(MW-ACC_W){wet_avg[ACC_W-1]}}, wet_avg};
    k_wet   = {{(MW-4){1'b0}}, wl_q};
    k_dry   = MW'(16) - k_wet;
    mix_sum = dry_ext * k_dry + wet_ext * k_wet;
    mix_sh  = mix_sum >>> 4;
`ifdef CHORUS_FEEDBACK_EN
    wr_word = sat_pkt(dry_ext + (wet_ext >>> 2));
`else
    wr_word = dry_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    dry_d    = dry_q;
    off_d    = off_q;
    wl_d     = wl_q;
    acc_d    = acc_q;
    mix_d    = mix_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    pkt_d    = pkt_q;
    vld_d    = 1'b0;
    ovr_d    = ovr_q;
    wr_en    = 1'b0;
    if (pktValid_i && (state_q != S_IDLE)) ovr_d = 1'b1;
    if (acc_en) acc_d = acc_q + tap_val;
    unique case (state_q)
      S_IDLE: begin
        if (pktValid_i) begin
          dry_d   = pkt_i;
          off_d   = voiceOffset_i;
          wl_d    = wetLevel_i;
          acc_d   = '0;
          v_d     = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        v_d = v_q + VW'(1);
        if (v_q == V_LAST) state_d = S_ACC;
      end
      S_ACC: state_d = S_MIX;
      S_MIX: begin
        mix_d   = sat_pkt(mix_sh);
        state_d = S_WR;
      end
      S_WR: begin
        wr_en    = 1'b1;
        wr_ptr_d = (wr_ptr_q == AW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (fill_q != FW'(BUF_DEPTH)) fill_d = fill_q + FW'(1);
        pkt_d    = mix_q;
        vld_d    = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      dry_q    <= '0;
      off_q    <= '0;
      wl_q     <= '0;
      acc_q    <= '0;
      mix_q    <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      pkt_q    <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      tap_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      dry_q    <= dry_d;
      off_q    <= off_d;
      wl_q     <= wl_d;
      acc_q    <= acc_d;
      mix_q    <= mix_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      tap_ok_q <= tap_ok_d;
    end
  end

  // Buffer contents survive reset; fill-count masking hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= wr_word;
    rd_data_q <= mem[rd_addr_d];
  end

  assign pkt_o      = pkt_q;
  assign pktValid_o = vld_q;
  assign busy_o     = (state_q != S_IDLE);
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_chorus_voice_engine.sv
// Scoreboard bench for chorus_voice_engine: depth-16 instance plus a depth-13 instance for the wrap check.
module tb_chorus_voice_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_i;
  logic        pkt_vld_i;
  logic [5:0]  voff_a;
  logic [3:0]  voff_b;
  logic [3:0]  wl;
  logic [15:0] pkt_o_a, pkt_o_b;
  logic        vld_o_a, vld_o_b, busy_a, busy_b, ovr_a, ovr_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];
  logic [15:0] e_a, e_b;
  bit chk_b = 1'b0;

  always #5 clk = ~clk;

  chorus_voice_engine #(.PKT_WIDTH(16), .BUF_DEPTH(16), .NUM_VOICES(2), .AVG_DELAY(8), .OFF_W(3)) dut_a (
    .clk(clk), .rst(rst), .pkt_i(pkt_i), .pktValid_i(pkt_vld_i), .voiceOffset_i(voff_a),
    .wetLevel_i(wl), .pkt_o(pkt_o_a), .pktValid_o(vld_o_a), .busy_o(busy_a), .overrun_o(ovr_a));

  chorus_voice_engine #(.PKT_WIDTH(16), .BUF_DEPTH(13), .NUM_VOICES(2), .AVG_DELAY(8), .OFF_W(2)) dut_b (
    .clk(clk), .rst(rst), .pkt_i(pkt_i), .pktValid_i(pkt_vld_i), .voiceOffset_i(voff_b),
    .wetLevel_i(wl), .pkt_o(pkt_o_b), .pktValid_o(vld_o_b), .busy_o(busy_b), .overrun_o(ovr_b));

  // Pop the scoreboard whenever a DUT strobes an output.
  always @(negedge clk) begin
    if (vld_o_a) begin
      total_cnt++;
      if (exp_qa.size() == 0) begin
        $display("FAIL out_a_unexpected: pktValid_o with pkt_o=%h, required no output", pkt_o_a);
      end else begin
        e_a = exp_qa.pop_front();
        if (pkt_o_a !== e_a) $display("FAIL out_a: pkt_o=%h required %h", pkt_o_a, e_a);
        else pass_cnt++;
      end
    end
    if (chk_b && vld_o_b) begin
      total_cnt++;
      if (exp_qb.size() == 0) begin
        $display("FAIL out_b_unexpected: pktValid_o with pkt_o=%h, required no output", pkt_o_b);
      end else begin
        e_b = exp_qb.pop_front();
        if (pkt_o_b !== e_b) $display("FAIL out_b: pkt_o=%h required %h", pkt_o_b, e_b);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_vld_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one strobe, queue its expected outputs and wait out the 6-cycle sample period.
  task automatic send(input logic [15:0] d, input logic [3:0] w, input logic [5:0] oa,
                      input logic [3:0] ob, input logic [15:0] ea, input logic [15:0] eb);
    pkt_i = d; wl = w; voff_a = oa; voff_b = ob; pkt_vld_i = 1'b1;
    exp_qa.push_back(ea);
    if (chk_b) exp_qb.push_back(eb);
    tick();
    pkt_vld_i = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wait_drain(output int pending);
    int n = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    pending = exp_qa.size() + exp_qb.size();
    exp_qa.delete();
    exp_qb.delete();
  endtask

  task automatic test_reset();
    int pend;
    int seen = 0;
    do_reset();
    total_cnt++;
    if ({pkt_o_a, vld_o_a, busy_a, ovr_a} !== 19'd0)
      $display("FAIL reset_state: pkt_o=%h vld=%b busy=%b ovr=%b required all 0", pkt_o_a, vld_o_a, busy_a, ovr_a);
    else pass_cnt++;
    send(16'h1234, 4'd0, 6'd0, 4'd0, 16'h1234, 16'h0);
    wait_drain(pend);
    total_cnt++;
    if (pend !== 0) $display("FAIL reset_first_drain: pending=%0d required 0", pend);
    else pass_cnt++;
    // Accept one sample, drop a second strobe in RD, then reset mid-sample.
    pkt_i = 16'h5555; wl = 4'd0; voff_a = 6'd0; pkt_vld_i = 1'b1;
    tick();
    tick();
    pkt_vld_i = 1'b0;
    total_cnt++;
    if ({busy_a, ovr_a} !== 2'b11) $display("FAIL reset_pre_busy_ovr: busy/ovr=%b required 11", {busy_a, ovr_a});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({pkt_o_a, vld_o_a, busy_a, ovr_a} !== 19'd0)
      $display("FAIL reset_mid_sample: pkt_o=%h vld=%b busy=%b ovr=%b required all 0", pkt_o_a, vld_o_a, busy_a, ovr_a);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (vld_o_a) seen++;
      tick();
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_discard: %0d outputs after reset, required 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_impulse();
    int pend;
    logic [15:0] ex;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      ex = (k == 0) ? 16'h0800 : ((k == 8 || k == 11) ? 16'h0400 : 16'h0000);
      send((k == 0) ? 16'h1000 : 16'h0000, 4'd8, {3'd3, 3'd0}, 4'd0, ex, 16'h0);
    end
    wait_drain(pend);
    total_cnt++;
    if (pend !== 0 || ovr_a !== 1'b0) $display("FAIL impulse_drain: pending=%0d ovr=%b required 0/0", pend, ovr_a);
    else pass_cnt++;
  endtask

  // Ramp through both depths; sends are back to back at the minimum spacing.
  task automatic test_wrap();
    int pend;
    int word [40];
    int w, o;
    do_reset();
    chk_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = (k >= 8) ? word[k-8] : 0;
      o = (k + w) >>> 1;
      word[k] = k;
`ifdef CHORUS_FEEDBACK_EN
      word[k] = k + (w >>> 2);
`endif
      send(16'(k), 4'd8, 6'd0, 4'd0, 16'(o), 16'(o));
    end
    wait_drain(pend);
    chk_b = 1'b0;
    total_cnt++;
    if (pend !== 0 || ovr_a !== 1'b0 || ovr_b !== 1'b0)
      $display("FAIL wrap_drain: pending=%0d ovr_a=%b ovr_b=%b required 0/0/0", pend, ovr_a, ovr_b);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int pend;
    int cnt = 0;
    int first = -1;
    do_reset();
    pkt_i = 16'h0100; wl = 4'd0; voff_a = 6'd0; pkt_vld_i = 1'b1;
    exp_qa.push_back(16'h0100);
    tick();
    pkt_vld_i = 1'b0;
    tick();
    pkt_vld_i = 1'b1;
    tick();
    pkt_vld_i = 1'b0;
    for (int cyc = 3; cyc < 21; cyc++) begin
      if (vld_o_a) begin
        cnt++;
        if (first < 0) first = cyc;
      end
      tick();
    end
    total_cnt++;
    if (cnt !== 1) $display("FAIL overrun_count: %0d outputs required 1", cnt);
    else pass_cnt++;
    total_cnt++;
    if (first !== 6) $display("FAIL overrun_latency: %0d clks required 6", first);
    else pass_cnt++;
    repeat (5) tick();
    total_cnt++;
    if (ovr_a !== 1'b1) $display("FAIL overrun_sticky: overrun_o=%b required 1", ovr_a);
    else pass_cnt++;
    wait_drain(pend);
    do_reset();
    total_cnt++;
    if (ovr_a !== 1'b0 || pend !== 0) $display("FAIL overrun_clear: overrun_o=%b pending=%0d required 0/0", ovr_a, pend);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    int pend;
    logic [15:0] d;
    logic [15:0] ex;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      d = 16'($urandom);
      send(d, 4'd0, 6'($urandom_range(0, 63)), 4'd0, d, 16'h0);
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      ex = (k < 8) ? 16'hF800 : ((k < 15) ? 16'hBC00 : 16'h8000);
      send(16'h8000, 4'd15, {3'd7, 3'd0}, 4'd0, ex, 16'h0);
    end
    wait_drain(pend);
    total_cnt++;
    if (pend !== 0) $display("FAIL extremes_drain: pending=%0d required 0", pend);
    else pass_cnt++;
  endtask

  task automatic test_feedback();
    int pend;
    logic [15:0] ex;
    do_reset();
    for (int k = 0; k < 18; k++)
      send((k == 0) ? 16'h4000 : 16'h0, 4'd0, 6'd0, 4'd0, (k == 0) ? 16'h4000 : 16'h0, 16'h0);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      ex = (k == 0) ? 16'h0400 : ((k == 8) ? 16'h3C00 : 16'h0000);
`ifdef CHORUS_FEEDBACK_EN
      if (k == 16) ex = 16'h0F00;
`endif
      send((k == 0) ? 16'h4000 : 16'h0, 4'd15, 6'd0, 4'd0, ex, 16'h0);
    end
    wait_drain(pend);
    total_cnt++;
    if (pend !== 0) $display("FAIL feedback_drain: pending=%0d required 0", pend);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; pkt_i = '0; pkt_vld_i = 1'b0; voff_a = '0; voff_b = '0; wl = '0;
    test_reset();
    test_impulse();
    test_wrap();
    test_overrun();
    test_extremes();
    test_feedback();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
